alu_bitserial_seq: RTL

- Bit-serial sequencer that feeds a single ALU_1bit slice one bit per clock, LSB first, and collects its outputs into a WIDTH-bit result.
- Holds the ripple carry in a flop between cycles and resolves signed SLT after the MSB cycle.
- Sits directly upstream of the 1-bit slice: drives its a/b/c/less/signal inputs and consumes its out/cout/set outputs.
- Lets a small datapath reuse one slice instead of a WIDTH-slice ripple array.

---
 rtl/alu_bitserial_seq.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_bitserial_seq.sv
// Bit-serial sequencer around a single external 1-bit ALU slice.
// Operands are fed LSB first, one bit per clock; carry, flags and SLT are resolved after the MSB cycle.
module alu_bitserial_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_cin,
    output logic             alu_less,
    output logic [2:0]       alu_signal,
    input  logic             alu_out,
    input  logic             alu_cout,
    input  logic             alu_set
);

    // state  | meaning
    // S_IDLE | waiting for start; done pulses here for one cycle after FIN
    // S_RUN  | one operand bit per cycle through the slice, LSB first
    // S_FIN  | final result and flags written to the output registers
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             err_pend_q, err_pend_d;
    logic             msb_set_q, msb_set_d;
    logic             msb_cout_q, msb_cout_d;
    logic             msb_ovf_q, msb_ovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic             op_legal;
    logic             op_is_logic;
    logic [WIDTH-1:0] final_res;

    always_comb begin
        op_legal = (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
                   (op == OP_SUB) || (op == OP_SLT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            opa_q      <= '0;
            opb_q      <= '0;
            op_q       <= '0;
            shreg_q    <= '0;
            err_pend_q <= 1'b0;
            msb_set_q  <= 1'b0;
            msb_cout_q <= 1'b0;
            msb_ovf_q  <= 1'b0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b1;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            op_q       <= op_d;
            shreg_q    <= shreg_d;
            err_pend_q <= err_pend_d;
            msb_set_q  <= msb_set_d;
            msb_cout_q <= msb_cout_d;
            msb_ovf_q  <= msb_ovf_d;
            result_q   <= result_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    // SLT replaces the shifted-in bits with the sign of A-B corrected for overflow
    always_comb begin
        op_is_logic = (op_q[1] == 1'b0);
        if (err_pend_q) begin
            final_res = '0;
        end else if (op_q == OP_SLT) begin
            final_res = {{(WIDTH-1){1'b0}}, msb_set_q ^ msb_ovf_q};
        end else begin
            final_res = shreg_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        op_d       = op_q;
        shreg_d    = shreg_q;
        err_pend_d = err_pend_q;
        msb_set_d  = msb_set_q;
        msb_cout_d = msb_cout_q;
        msb_ovf_d  = msb_ovf_q;
        result_d   = result_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        err_d      = err_q;
        done_d     = (state_q == S_FIN);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op_legal) begin
                        opa_d      = opa;
                        opb_d      = opb;
                        op_d       = op;
                        cnt_d      = '0;
                        carry_d    = op[2];
                        err_pend_d = 1'b0;
                        state_d    = S_RUN;
                    end else begin
                        err_pend_d = 1'b1;
                        state_d    = S_FIN;
                    end
                end
            end
            S_RUN: begin
                shreg_d = {alu_out, shreg_q[WIDTH-1:1]};
                carry_d = alu_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    msb_set_d  = alu_set;
                    msb_cout_d = alu_cout;
                    msb_ovf_d  = carry_q ^ alu_cout;
                    state_d    = S_FIN;
                end
            end
            S_FIN: begin
                result_d = final_res;
                zero_d   = (final_res == '0);
                err_d    = err_pend_q;
                if (err_pend_q || op_is_logic) begin
                    cout_d = 1'b0;
                    ovf_d  = 1'b0;
                end else begin
                    cout_d = msb_cout_q;
                    ovf_d  = msb_ovf_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        alu_a      = 1'b0;
        alu_b      = 1'b0;
        alu_cin    = 1'b0;
        alu_less   = 1'b0;
        alu_signal = op_q;
        if (state_q == S_RUN) begin
            alu_a   = opa_q[cnt_q];
            alu_b   = opb_q[cnt_q];
            alu_cin = carry_q;
        end
    end

    assign busy   = (state_q == S_RUN) || (state_q == S_FIN);
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule
